// File: rtl/dsm_sample_scheduler_pkg.sv
// Shared types and constants for the delta-sigma sample scheduler.
//   DSM_WIDTH_DEFAULT : default PCM word width (offset-binary)
//   asm_state_e       : L/R beat assembler state
//   dsm_frame_t       : stereo frame {left, right} at the default width
//   midscale()        : offset-binary zero level, 1 << (width-1)
package dsm_sample_scheduler_pkg;

  localparam int unsigned DSM_WIDTH_DEFAULT = 12;

  typedef enum logic {
    EXPECT_L = 1'b0,
    EXPECT_R = 1'b1
  } asm_state_e;

  typedef struct packed {
    logic [DSM_WIDTH_DEFAULT-1:0] left;
    logic [DSM_WIDTH_DEFAULT-1:0] right;
  } dsm_frame_t;

  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dsm_sample_scheduler_if.sv
// Interleaved L/R sample beat stream (valid/ready).
//   s_data  : sample beat
//   s_right : channel tag, 0=left 1=right
//   s_valid : beat valid (source)
//   s_ready : beat accepted when s_valid && s_ready (sink)
interface dsm_sample_scheduler_if #(
  parameter int unsigned DSM_WIDTH = 12
) ();

  logic [DSM_WIDTH-1:0] s_data;
  logic                 s_right;
  logic                 s_valid;
  logic                 s_ready;

  modport master (
    output s_data,
    output s_right,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_right,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/dsm_frame_fifo.sv
// Synchronous show-ahead FIFO for stereo frames.
//   clk, rst  : clock, synchronous active-high reset (flushes contents)
//   push      : write push_data (ignored when full)
//   pop       : drop head entry (ignored when empty); pop_data is the head
//   full/empty: occupancy flags
//   level     : number of stored entries, 0..DEPTH
module dsm_frame_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (level == LW'(DEPTH));
    empty    = (level == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dsm_sample_scheduler.sv
// Paces stereo PCM frames into dsm_stereo at one frame per RATE_DIV clocks.
//   clk, aclr   : clock, synchronous active-high reset
//   s           : interleaved L/R beat stream (slave side)
//   mute        : sampled at tick, forces midscale output
//   clr_status  : clears underrun and sync_err (a coincident set wins)
//   left_pcm    : registered left sample to dsm_stereo
//   right_pcm   : registered right sample to dsm_stereo
//   frame_tick  : 1-cycle pulse coincident with a new left/right_pcm
//   fifo_level  : frames buffered
//   underrun    : sticky, an unmuted tick found the FIFO empty
//   sync_err    : sticky, a beat arrived with an out-of-order channel tag
module dsm_sample_scheduler
  import dsm_sample_scheduler_pkg::*;
#(
  parameter int unsigned DSM_WIDTH  = DSM_WIDTH_DEFAULT,
  parameter int unsigned RATE_DIV   = 4096,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          aclr,
  dsm_sample_scheduler_if.slave         s,
  input  logic                          mute,
  input  logic                          clr_status,
  output logic [DSM_WIDTH-1:0]          left_pcm,
  output logic [DSM_WIDTH-1:0]          right_pcm,
  output logic                          frame_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          sync_err
);

  localparam logic [DSM_WIDTH-1:0] MIDSCALE = DSM_WIDTH'(midscale(DSM_WIDTH));
  localparam int unsigned          CW       = $clog2(RATE_DIV);

  typedef struct packed {
    logic [DSM_WIDTH-1:0] left;
    logic [DSM_WIDTH-1:0] right;
  } frame_t;

  asm_state_e           state;
  asm_state_e           state_next;
  logic [DSM_WIDTH-1:0] hold;
  logic                 ready;
  logic                 accept;
  logic                 hold_load;
  logic                 fifo_push;
  logic                 sync_set;

  logic [CW-1:0]        div_cnt;
  logic                 tick;

  frame_t               push_frame;
  frame_t               pop_frame;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 underrun_set;

  dsm_frame_fifo #(
    .WIDTH (2 * DSM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (aclr),
    .push      (fifo_push),
    .push_data (push_frame),
    .pop       (fifo_pop),
    .pop_data  (pop_frame),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Assembler FSM: state register
  always_ff @(posedge clk) begin
    if (aclr) begin
      state <= EXPECT_L;
    end else begin
      state <= state_next;
    end
  end

  // Assembler FSM: next state. A stray left beat while expecting right
  // restarts the pair without leaving EXPECT_R.
  always_comb begin
    state_next = state;
    unique case (state)
      EXPECT_L: if (accept && !s.s_right) state_next = EXPECT_R;
      EXPECT_R: if (accept &&  s.s_right) state_next = EXPECT_L;
      default:  state_next = EXPECT_L;
    endcase
  end

  // Assembler FSM: outputs
  always_comb begin
    ready      = 1'b0;
    hold_load  = 1'b0;
    fifo_push  = 1'b0;
    sync_set   = 1'b0;
    if (!aclr) begin
      ready = (state == EXPECT_L) ? 1'b1 : !fifo_full;
    end
    accept = s.s_valid && ready;
    unique case (state)
      EXPECT_L: begin
        if (accept) begin
          if (s.s_right) sync_set  = 1'b1;
          else           hold_load = 1'b1;
        end
      end
      EXPECT_R: begin
        if (accept) begin
          if (s.s_right) begin
            fifo_push = 1'b1;
          end else begin
            hold_load = 1'b1;
            sync_set  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign s.s_ready = ready;
  assign push_frame = '{left: hold, right: s.s_data};

  always_ff @(posedge clk) begin
    if (aclr) begin
      hold <= '0;
    end else if (hold_load) begin
      hold <= s.s_data;
    end
  end

  // Rate divider
  assign tick = (div_cnt == CW'(RATE_DIV - 1));

  always_ff @(posedge clk) begin
    if (aclr) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frames are consumed on every tick, even while muted, so the stream
  // stays in step with the sample clock.
  assign fifo_pop     = tick && !fifo_empty;
  assign underrun_set = tick && !mute && fifo_empty;

  always_ff @(posedge clk) begin
    if (aclr) begin
      left_pcm   <= MIDSCALE;
      right_pcm  <= MIDSCALE;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick;
      if (tick) begin
        if (mute) begin
          left_pcm  <= MIDSCALE;
          right_pcm <= MIDSCALE;
        end else if (!fifo_empty) begin
          left_pcm  <= pop_frame.left;
          right_pcm <= pop_frame.right;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      underrun <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (underrun_set)    underrun <= 1'b1;
      else if (clr_status) underrun <= 1'b0;
      if (sync_set)        sync_err <= 1'b1;
      else if (clr_status) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsm_sample_scheduler.sv
module tb_dsm_sample_scheduler;

  logic        clk = 1'b0;
  logic        aclr;
  logic        mute;
  logic        clr_status;
  logic [11:0] left_pcm, right_pcm;
  logic        frame_tick;
  logic [2:0]  fifo_level;
  logic        underrun, sync_err;

  logic [11:0] left2, right2;
  logic        frame_tick2;
  logic [2:0]  fifo_level2;
  logic        underrun2, sync_err2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsm_sample_scheduler_if #(.DSM_WIDTH(12)) s_if ();
  dsm_sample_scheduler_if #(.DSM_WIDTH(12)) s2_if ();

  dsm_sample_scheduler #(
    .DSM_WIDTH  (12),
    .RATE_DIV   (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .s          (s_if.slave),
    .mute       (mute),
    .clr_status (clr_status),
    .left_pcm   (left_pcm),
    .right_pcm  (right_pcm),
    .frame_tick (frame_tick),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .sync_err   (sync_err)
  );

  dsm_sample_scheduler #(
    .DSM_WIDTH  (12),
    .RATE_DIV   (4096),
    .FIFO_DEPTH (4)
  ) dut_slow (
    .clk        (clk),
    .aclr       (aclr),
    .s          (s2_if.slave),
    .mute       (1'b0),
    .clr_status (1'b0),
    .left_pcm   (left2),
    .right_pcm  (right2),
    .frame_tick (frame_tick2),
    .fifo_level (fifo_level2),
    .underrun   (underrun2),
    .sync_err   (sync_err2)
  );

  task automatic do_reset();
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic send_beat(input logic [11:0] d, input logic r);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    s_if.s_data  = d;
    s_if.s_right = r;
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s_if.s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    s_if.s_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL beat_accept data=%0d right=%0d got=not_accepted exp=accepted", d, r);
    end
  endtask

  task automatic wait_tick(output int cyc, output bit found);
    found = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        found = 1'b1;
        cyc   = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int first;
    aclr = 1'b1; mute = 1'b0; clr_status = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_right = 1'b0;
    s2_if.s_valid = 1'b0; s2_if.s_data = '0; s2_if.s_right = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", s_if.s_ready); end
    checks++; if (left_pcm !== 12'd2048) begin errors++; $display("FAIL rst_left got=%0d exp=2048", left_pcm); end
    checks++; if (right_pcm !== 12'd2048) begin errors++; $display("FAIL rst_right got=%0d exp=2048", right_pcm); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
    checks++; if (underrun !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", underrun, sync_err); end
    aclr = 1'b0;
    #1;
    checks++; if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", s_if.s_ready); end
    first = 0;
    for (int k = 1; k <= 4096; k++) begin
      @(negedge clk);
      if (frame_tick2 === 1'b1 && first == 0) first = k;
    end
    checks++; if (first != 4096) begin errors++; $display("FAIL slow_first_tick got=%0d exp=4096", first); end
    checks++; if (underrun2 !== 1'b1) begin errors++; $display("FAIL slow_underrun got=%b exp=1", underrun2); end
    checks++; if (left2 !== 12'd2048 || right2 !== 12'd2048) begin errors++; $display("FAIL slow_hold got=%0d/%0d exp=2048/2048", left2, right2); end
    checks++; if (fifo_level2 !== 3'd0 || sync_err2 !== 1'b0 || s2_if.s_ready !== 1'b1) begin
      errors++; $display("FAIL slow_idle got=lvl%0d se%b rdy%b exp=lvl0 se0 rdy1", fifo_level2, sync_err2, s2_if.s_ready);
    end
  endtask

  // Covers the basic stream and then the underrun / clr_status behaviour
  task automatic test_stream_underrun();
    int cyc; bit found;
    do_reset();
    send_beat(12'd127, 1'b0); send_beat(12'd1024, 1'b1);
    send_beat(12'd0, 1'b0);   send_beat(12'd3750, 1'b1);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL s_level2 got=%0d exp=2", fifo_level); end
    wait_tick(cyc, found);
    checks++; if (!found) begin errors++; $display("FAIL s_tick1 got=timeout exp=tick"); end
    checks++; if (left_pcm !== 12'd127 || right_pcm !== 12'd1024) begin errors++; $display("FAIL s_frame1 got=%0d/%0d exp=127/1024", left_pcm, right_pcm); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL s_level1 got=%0d exp=1", fifo_level); end
    wait_tick(cyc, found);
    checks++; if (!found || cyc != 16) begin errors++; $display("FAIL s_spacing got=%0d exp=16", cyc); end
    checks++; if (left_pcm !== 12'd0 || right_pcm !== 12'd3750) begin errors++; $display("FAIL s_frame2 got=%0d/%0d exp=0/3750", left_pcm, right_pcm); end
    checks++; if (fifo_level !== 3'd0 || underrun !== 1'b0) begin errors++; $display("FAIL s_level0 got=lvl%0d ur%b exp=lvl0 ur0", fifo_level, underrun); end
    wait_tick(cyc, found);
    checks++; if (!found || cyc != 16) begin errors++; $display("FAIL u_tick got=%0d exp=16", cyc); end
    checks++; if (left_pcm !== 12'd0 || right_pcm !== 12'd3750) begin errors++; $display("FAIL u_hold got=%0d/%0d exp=0/3750", left_pcm, right_pcm); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL u_set got=%b exp=1", underrun); end
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL u_clear got=%b exp=0", underrun); end
    repeat (13) @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++; if (frame_tick !== 1'b1 || underrun !== 1'b1) begin errors++; $display("FAIL u_set_wins got=tick%b ur%b exp=tick1 ur1", frame_tick, underrun); end
  endtask

  task automatic test_backpressure();
    int cyc; bit found; bit ok;
    logic [11:0] exp_l [4];
    logic [11:0] exp_r [4];
    exp_l = '{12'd20, 12'd30, 12'd40, 12'd5};
    exp_r = '{12'd21, 12'd31, 12'd41, 12'd6};
    do_reset();
    send_beat(12'd10, 1'b0); send_beat(12'd11, 1'b1);
    send_beat(12'd20, 1'b0); send_beat(12'd21, 1'b1);
    send_beat(12'd30, 1'b0); send_beat(12'd31, 1'b1);
    send_beat(12'd40, 1'b0); send_beat(12'd41, 1'b1);
    send_beat(12'd5, 1'b0);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_full got=%0d exp=4", fifo_level); end
    checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", s_if.s_ready); end
    s_if.s_data = 12'd6; s_if.s_right = 1'b1; s_if.s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_if.s_ready === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || frame_tick !== 1'b1) begin errors++; $display("FAIL bp_release got=rdy%b tick%b exp=rdy1 tick1", ok, frame_tick); end
    checks++; if (left_pcm !== 12'd10 || right_pcm !== 12'd11) begin errors++; $display("FAIL bp_pop1 got=%0d/%0d exp=10/11", left_pcm, right_pcm); end
    @(posedge clk); #1;
    s_if.s_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_refill got=%0d exp=4", fifo_level); end
    for (int j = 0; j < 4; j++) begin
      wait_tick(cyc, found);
      checks++;
      if (!found || left_pcm !== exp_l[j] || right_pcm !== exp_r[j]) begin
        errors++; $display("FAIL bp_order%0d got=%0d/%0d exp=%0d/%0d", j, left_pcm, right_pcm, exp_l[j], exp_r[j]);
      end
    end
  endtask

  task automatic test_sync_err();
    int cyc; bit found;
    do_reset();
    send_beat(12'd9, 1'b1);
    send_beat(12'd100, 1'b0);
    send_beat(12'd200, 1'b0);
    send_beat(12'd300, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL se_set got=%b exp=1", sync_err); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL se_level got=%0d exp=1", fifo_level); end
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL se_clear got=%b exp=0", sync_err); end
    wait_tick(cyc, found);
    checks++; if (!found || left_pcm !== 12'd200 || right_pcm !== 12'd300) begin errors++; $display("FAIL se_frame got=%0d/%0d exp=200/300", left_pcm, right_pcm); end
  endtask

  task automatic test_mute_reset();
    int cyc; bit found;
    do_reset();
    send_beat(12'd1, 1'b0); send_beat(12'd2, 1'b1);
    send_beat(12'd3, 1'b0); send_beat(12'd4, 1'b1);
    mute = 1'b1;
    wait_tick(cyc, found);
    mute = 1'b0;
    checks++; if (!found || left_pcm !== 12'd2048 || right_pcm !== 12'd2048) begin errors++; $display("FAIL mu_out got=%0d/%0d exp=2048/2048", left_pcm, right_pcm); end
    checks++; if (fifo_level !== 3'd1 || underrun !== 1'b0) begin errors++; $display("FAIL mu_level got=lvl%0d ur%b exp=lvl1 ur0", fifo_level, underrun); end
    wait_tick(cyc, found);
    checks++; if (!found || left_pcm !== 12'd3 || right_pcm !== 12'd4) begin errors++; $display("FAIL mu_next got=%0d/%0d exp=3/4", left_pcm, right_pcm); end
    send_beat(12'd5, 1'b0); send_beat(12'd6, 1'b1);
    send_beat(12'd77, 1'b0);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL mr_pre got=%0d exp=1", fifo_level); end
    do_reset();
    #1;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mr_level got=%0d exp=0", fifo_level); end
    checks++; if (left_pcm !== 12'd2048 || right_pcm !== 12'd2048) begin errors++; $display("FAIL mr_out got=%0d/%0d exp=2048/2048", left_pcm, right_pcm); end
    send_beat(12'd8, 1'b1);
    @(negedge clk);
    checks++; if (sync_err !== 1'b1 || fifo_level !== 3'd0) begin errors++; $display("FAIL mr_expect_l got=se%b lvl%0d exp=se1 lvl0", sync_err, fifo_level); end
  endtask

  initial begin
    test_reset();
    test_stream_underrun();
    test_backpressure();
    test_sync_err();
    test_mute_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
